mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 3: cycles from request sample to mem_resp; legal range 1..15.
REQ-002 SHALL have parameter DEPTH_LOG2, default 8: word-array depth 2^DEPTH_LOG2 (256 x 32-bit words).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port mem_read  input  1  read request, held by initiator until mem_resp.
REQ-006 SHALL have port mem_write  input  1  write request, held by initiator until mem_resp.
REQ-007 SHALL have port mem_byte_enable  input  4  per-byte write mask; bit i selects wdata[8i+7:8i].
REQ-008 SHALL have port mem_address  input  32  byte address; word index = mem_address[DEPTH_LOG2+1:2].
REQ-009 SHALL have port mem_wdata  input  32  write data.
REQ-010 SHALL have port mem_rdata  output  32  read data, valid only while mem_resp=1 for a read.
REQ-011 SHALL have port mem_resp  output  1  one-cycle completion pulse.
REQ-012 SHALL have port protocol_err  output  1  sticky protocol-violation flag.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-014 In IDLE, mem_read^mem_write=1 SHALL capture op, word index, wdata, byte_enable, load counter with LATENCY-1, go BUSY (LATENCY=1: go RESP directly).
REQ-015 In IDLE, mem_read=mem_write=1 SHALL set protocol_err, accept no request, stay IDLE.
REQ-016 In BUSY, counter SHALL decrement each cycle; at counter=1 go RESP.
REQ-017 Request sampled at edge T SHALL yield mem_resp=1 in exactly the cycle after edge T+LATENCY-1 (i.e. LATENCY cycles after sampling); mem_resp=0 in every other cycle.
REQ-018 In RESP, read SHALL drive mem_rdata = array[captured index]; write SHALL drive mem_rdata = 0.
REQ-019 Write SHALL commit at the edge ending the RESP cycle, updating only bytes with byte_enable=1; byte_enable=4'b0000 SHALL still respond and leave array unchanged.
REQ-020 RESP SHALL always return to IDLE; new request SHALL be sampled in the IDLE cycle immediately after RESP (back-to-back throughput: 1 request per LATENCY+1 cycles).
REQ-021 Outside RESP-of-read, mem_rdata SHALL be 32'h0.
REQ-022 In BUSY or RESP, captured values SHALL be used; input changes SHALL not alter the transaction.
REQ-023 In BUSY, deassertion of the captured request signal, assertion of the other request, or mem_address differing from captured address SHALL set protocol_err; transaction SHALL still complete normally.
REQ-024 Address bits [1:0] and bits above DEPTH_LOG2+1 SHALL be ignored (aliasing wraps).
REQ-025 Read of a word written by an immediately preceding transaction SHALL return the updated value.
REQ-026 protocol_err SHALL remain 1 until rst.

Reset
REQ-027 rst=1 at an edge SHALL force IDLE, counter 0, mem_resp 0, mem_rdata 0, protocol_err 0.
REQ-028 rst during BUSY or RESP SHALL abort transaction with no array write and no mem_resp pulse.
REQ-029 Array contents SHALL not be affected by rst.
REQ-030 First request SHALL be sampled no earlier than the first edge with rst=0.

Verification
REQ-031 LATENCY=3: write addr 0x10, wdata 0xDEADBEEF, be 4'hF; then read 0x10 -> mem_resp exactly 3 cycles after each sample; read returns 0xDEADBEEF.
REQ-032 Write 0x11223344 to 0x20, then write 0xAABBCCDD with be 4'b0101 to 0x22 -> read 0x20 returns 0x11BB33DD.
REQ-033 Back-to-back reads of 0x10 and 0x14, second request asserted in the cycle after first resp -> two resp pulses 4 cycles apart; no protocol_err.
REQ-034 mem_read and mem_write both 1 in IDLE -> protocol_err=1, no mem_resp; remains 1 until rst.
REQ-035 Write 0x12345678 to 0x30, rst asserted one cycle after sampling -> no mem_resp; subsequent read of 0x30 returns prior contents.
REQ-036 LATENCY=1 and address 0x410 (DEPTH_LOG2=8) -> resp next cycle; aliases word index 4 (address 0x010).

Source files
------------

// File: rtl/mem_responder.sv
// Single-ported word memory answering one read/write request at a time
// after a fixed LATENCY, with sticky detection of initiator misbehaviour.
//
// Ports:
//   clk             sole clock, rising edge
//   rst             synchronous active-high reset (array is not reset)
//   mem_read        read request, held until mem_resp
//   mem_write       write request, held until mem_resp
//   mem_byte_enable per-byte write mask (bit i -> wdata[8i+7:8i])
//   mem_address     byte address; word index = mem_address[DEPTH_LOG2+1:2]
//   mem_wdata       write data
//   mem_rdata       read data during the response cycle of a read, else 0
//   mem_resp        one-cycle completion pulse
//   protocol_err    sticky protocol-violation flag, cleared only by rst
module mem_responder #(
    parameter int unsigned LATENCY    = 3,
    parameter int unsigned DEPTH_LOG2 = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic        protocol_err
);

    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [3:0]            cnt_q;
    logic [3:0]            cnt_d;
    logic                  perr_q;
    logic                  perr_d;
    logic                  capture;

    logic                  op_wr_q;
    logic [31:0]           addr_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [31:0]           wdata_q;
    logic [3:0]            be_q;

    logic [31:0]           mem [DEPTH];

    logic                  req_lost;
    logic                  req_other;
    logic                  addr_moved;

    // Initiator must keep the captured request steady while we are busy.
    assign req_lost   = op_wr_q ? !mem_write : !mem_read;
    assign req_other  = op_wr_q ? mem_read : mem_write;
    assign addr_moved = (mem_address != addr_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        perr_d  = perr_q;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_read && mem_write) begin
                    perr_d = 1'b1;
                end else if (mem_read || mem_write) begin
                    capture = 1'b1;
                    cnt_d   = CNT_LOAD;
                    // A load value of zero means LATENCY=1: skip BUSY.
                    state_d = (CNT_LOAD == 4'd0) ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (req_lost || req_other || addr_moved) begin
                    perr_d = 1'b1;
                end
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            perr_q  <= perr_d;
        end
    end

    // Transaction context; only meaningful while not IDLE, so no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            op_wr_q <= mem_write;
            addr_q  <= mem_address;
            idx_q   <= mem_address[DEPTH_LOG2+1:2];
            wdata_q <= mem_wdata;
            be_q    <= mem_byte_enable;
        end
    end

    // Write commits on the edge that ends RESP, unless rst aborts it.
    always_ff @(posedge clk) begin
        if (!rst && state_q == RESP && op_wr_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    assign mem_resp     = (state_q == RESP);
    assign mem_rdata    = (state_q == RESP && !op_wr_q) ? mem[idx_q] : 32'h0;
    assign protocol_err = perr_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed, table-driven bench for mem_responder: one instance at
// LATENCY=3 and one at LATENCY=1, plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_read, a_write;
    logic [3:0]  a_be;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic        a_resp, a_perr;

    logic        b_read, b_write;
    logic [3:0]  b_be;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic        b_resp, b_perr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_responder #(.LATENCY(3), .DEPTH_LOG2(8)) dut_a (
        .clk(clk), .rst(rst),
        .mem_read(a_read), .mem_write(a_write),
        .mem_byte_enable(a_be), .mem_address(a_addr),
        .mem_wdata(a_wdata), .mem_rdata(a_rdata),
        .mem_resp(a_resp), .protocol_err(a_perr)
    );

    mem_responder #(.LATENCY(1), .DEPTH_LOG2(8)) dut_b (
        .clk(clk), .rst(rst),
        .mem_read(b_read), .mem_write(b_write),
        .mem_byte_enable(b_be), .mem_address(b_addr),
        .mem_wdata(b_wdata), .mem_rdata(b_rdata),
        .mem_resp(b_resp), .protocol_err(b_perr)
    );

    typedef struct {
        bit          sel;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be);
        if (!sel) begin
            a_read = rd; a_write = wr; a_addr = addr;
            a_wdata = wd; a_be = be;
        end else begin
            b_read = rd; b_write = wr; b_addr = addr;
            b_wdata = wd; b_be = be;
        end
    endtask

    task automatic wait_resp(input bit sel, input int max,
                             output int k, output logic [31:0] d);
        k = 0;
        d = '0;
        for (int i = 1; i <= max && k == 0; i++) begin
            @(posedge clk);
            #1;
            if ((sel ? b_resp : a_resp) === 1'b1) begin
                k = i;
                d = sel ? b_rdata : a_rdata;
            end
        end
    endtask

    task automatic txn(input bit sel, input logic rd,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be,
                       output logic [31:0] d, output int lat);
        @(negedge clk);
        drive(sel, rd, !rd, addr, wd, be);
        wait_resp(sel, 40, lat, d);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_resp"}, {31'b0, a_resp}, 32'h0);
        chk({tag, "_rdata"}, a_rdata, 32'h0);
        chk({tag, "_perr_a"}, {31'b0, a_perr}, 32'h0);
        chk({tag, "_perr_b"}, {31'b0, b_perr}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] d, d2;
        int          lat, k2, seen;

        vt.push_back('{0, 0, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        3});
        vt.push_back('{0, 1, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 3});
        vt.push_back('{0, 0, 32'h20,  32'h11223344, 4'hF, 32'h0,        3});
        vt.push_back('{0, 0, 32'h22,  32'hAABBCCDD, 4'h5, 32'h0,        3});
        vt.push_back('{0, 1, 32'h20,  32'h0,        4'h0, 32'h11BB33DD, 3});
        vt.push_back('{0, 0, 32'h14,  32'h01020304, 4'hF, 32'h0,        3});
        vt.push_back('{0, 0, 32'h14,  32'hFFFFFFFF, 4'h0, 32'h0,        3});
        vt.push_back('{0, 1, 32'h14,  32'h0,        4'h0, 32'h01020304, 3});
        vt.push_back('{0, 0, 32'h413, 32'h55667788, 4'h8, 32'h0,        3});
        vt.push_back('{0, 1, 32'h10,  32'h0,        4'h0, 32'h55ADBEEF, 3});
        vt.push_back('{0, 0, 32'h30,  32'h0BADF00D, 4'hF, 32'h0,        3});
        vt.push_back('{0, 1, 32'h430, 32'h0,        4'h0, 32'h0BADF00D, 3});
        vt.push_back('{1, 0, 32'h410, 32'h600DCAFE, 4'hF, 32'h0,        1});
        vt.push_back('{1, 1, 32'h010, 32'h0,        4'h0, 32'h600DCAFE, 1});
        vt.push_back('{1, 1, 32'h410, 32'h0,        4'h0, 32'h600DCAFE, 1});

        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (2) @(posedge clk);
        do_reset("reset");

        foreach (vt[i]) begin
            txn(vt[i].sel, vt[i].rd, vt[i].addr, vt[i].wdata,
                vt[i].be, d, lat);
            chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
            chk($sformatf("v%0d_rdata", i), d, vt[i].exp);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pulse", i),
                {31'b0, vt[i].sel ? b_resp : a_resp}, 32'h0);
            chk($sformatf("v%0d_idle_rdata", i),
                vt[i].sel ? b_rdata : a_rdata, 32'h0);
            chk($sformatf("v%0d_perr", i),
                {31'b0, vt[i].sel ? b_perr : a_perr}, 32'h0);
        end

        // Back-to-back reads: second asserted in the IDLE cycle after resp.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        wait_resp(0, 20, lat, d);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'h14, 32'h0, 4'h0);
        wait_resp(0, 20, k2, d2);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("b2b_first", d, 32'h55ADBEEF);
        chk("b2b_second", d2, 32'h01020304);
        chk("b2b_gap", (k2 == 0) ? 0 : k2 + 1, 4);
        chk("b2b_perr", {31'b0, a_perr}, 32'h0);

        // Reset one cycle after a write is sampled aborts it silently.
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 32'h30, 32'h12345678, 4'hF);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (a_resp === 1'b1) seen++;
        end
        chk("abort_resp", seen, 0);
        txn(0, 1'b1, 32'h30, 32'h0, 4'h0, d, lat);
        chk("abort_lat", lat, 3);
        chk("abort_keep", d, 32'h0BADF00D);

        // Address changes while BUSY: flagged, captured address still used.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        @(posedge clk);
        @(negedge clk);
        a_addr = 32'h14;
        wait_resp(0, 20, lat, d);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("busy_lat", lat, 2);
        chk("busy_rdata", d, 32'h55ADBEEF);
        chk("busy_perr", {31'b0, a_perr}, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_perr_sticky", {31'b0, a_perr}, 32'h1);
        do_reset("clr1");

        // Read and write together in IDLE: error, no response.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h10, 32'h0, 4'hF);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (a_resp === 1'b1) seen++;
        end
        chk("both_resp", seen, 0);
        chk("both_perr", {31'b0, a_perr}, 32'h1);
        txn(0, 1'b1, 32'h10, 32'h0, 4'h0, d, lat);
        chk("both_perr_hold", {31'b0, a_perr}, 32'h1);
        chk("both_after_rd", d, 32'h55ADBEEF);
        do_reset("clr2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
